// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - RV32I ALU plus iterative RV32M divider feeding the EX/MEM pipe
module ex_stage #(
    parameter int XLEN  = 32,
    parameter int RF_AW = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id2ex_reg_wen,
    input  logic [RF_AW-1:0] id2ex_reg_waddr,
    input  logic             id2ex_ill_instr,
    input  logic [XLEN-1:0]  id2ex_op1,
    input  logic [XLEN-1:0]  id2ex_op2,
    input  logic [3:0]       id2ex_alu_op,
    input  logic             id2ex_div_req,
    input  logic [1:0]       id2ex_div_op,
    output logic             ex_stall,
    output logic             ex2mem_reg_wen,
    output logic [RF_AW-1:0] ex2mem_reg_waddr,
    output logic [XLEN-1:0]  ex2mem_alu_out,
    output logic             ex2mem_ill_instr
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state, state_nxt;

    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] quo, rem, dvs;
    logic            neg_q, neg_r, is_rem;
    logic [XLEN-1:0] alu_res, div_res;
    logic [4:0]      shamt;

    assign shamt = id2ex_op2[4:0];

    always_comb begin
        alu_res = '0;
        case (id2ex_alu_op)
            4'd0:  alu_res = id2ex_op1 + id2ex_op2;
            4'd1:  alu_res = id2ex_op1 - id2ex_op2;
            4'd2:  alu_res = id2ex_op1 << shamt;
            4'd3:  alu_res = {{(XLEN-1){1'b0}}, $signed(id2ex_op1) < $signed(id2ex_op2)};
            4'd4:  alu_res = {{(XLEN-1){1'b0}}, id2ex_op1 < id2ex_op2};
            4'd5:  alu_res = id2ex_op1 ^ id2ex_op2;
            4'd6:  alu_res = id2ex_op1 >> shamt;
            4'd7:  alu_res = XLEN'($signed(id2ex_op1) >>> shamt);
            4'd8:  alu_res = id2ex_op1 | id2ex_op2;
            4'd9:  alu_res = id2ex_op1 & id2ex_op2;
            4'd10: alu_res = id2ex_op2;
            default: alu_res = '0;
        endcase
    end

    // DIV/REM (codes 0,2) are signed; bit 1 selects remainder
    logic            div_go, is_signed, op1_neg, op2_neg, div_zero, div_ovf;
    logic [XLEN-1:0] abs1, abs2;

    assign div_go    = id2ex_div_req & id2ex_reg_wen & ~id2ex_ill_instr;
    assign is_signed = ~id2ex_div_op[0];
    assign op1_neg   = is_signed & id2ex_op1[XLEN-1];
    assign op2_neg   = is_signed & id2ex_op2[XLEN-1];
    assign abs1      = op1_neg ? -id2ex_op1 : id2ex_op1;
    assign abs2      = op2_neg ? -id2ex_op2 : id2ex_op2;
    assign div_zero  = (id2ex_op2 == '0);
    assign div_ovf   = is_signed && (id2ex_op1 == {1'b1, {(XLEN-1){1'b0}}}) && (id2ex_op2 == '1);

    logic [XLEN:0] rem_sh, diff;
    assign rem_sh  = {rem, quo[XLEN-1]};
    assign diff    = rem_sh - {1'b0, dvs};
    assign div_res = is_rem ? (neg_r ? -rem : rem) : (neg_q ? -quo : quo);

    always_comb begin
        state_nxt = state;
        ex_stall  = 1'b0;
        case (state)
            IDLE: if (div_go) begin
                ex_stall  = 1'b1;
                state_nxt = (div_zero || div_ovf) ? DONE : BUSY;
            end
            BUSY: begin
                ex_stall = 1'b1;
                if (cnt == CW'(XLEN-1)) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Special cases preload the final quotient/remainder with sign fix-up disabled
    always_ff @(posedge clk) begin
        if (state == IDLE && div_go) begin
            cnt    <= '0;
            is_rem <= id2ex_div_op[1];
            if (div_zero) begin
                quo <= '1;   rem <= id2ex_op1; neg_q <= 1'b0; neg_r <= 1'b0;
            end else if (div_ovf) begin
                quo <= id2ex_op1; rem <= '0; neg_q <= 1'b0; neg_r <= 1'b0;
            end else begin
                quo   <= abs1;
                rem   <= '0;
                dvs   <= abs2;
                neg_q <= op1_neg ^ op2_neg;
                neg_r <= op1_neg;
            end
        end else if (state == BUSY) begin
            cnt <= cnt + 1'b1;
            if (!diff[XLEN]) begin
                rem <= diff[XLEN-1:0];
                quo <= {quo[XLEN-2:0], 1'b1};
            end else begin
                rem <= rem_sh[XLEN-1:0];
                quo <= {quo[XLEN-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex2mem_reg_wen   <= 1'b0;
            ex2mem_ill_instr <= 1'b0;
        end else if (state == DONE) begin
            ex2mem_reg_wen   <= 1'b1;
            ex2mem_ill_instr <= 1'b0;
        end else if (ex_stall) begin
            ex2mem_reg_wen   <= 1'b0;
            ex2mem_ill_instr <= 1'b0;
        end else begin
            ex2mem_reg_wen   <= id2ex_reg_wen & ~id2ex_ill_instr;
            ex2mem_ill_instr <= id2ex_ill_instr;
        end
    end

    always_ff @(posedge clk) begin
        ex2mem_reg_waddr <= id2ex_reg_waddr;
        ex2mem_alu_out   <= (state == DONE) ? div_res : alu_res;
    end
endmodule
